// File: rtl/bet_recorder.sv
// Roulette bet recorder: captures chip/square keypresses into packed slots and runs the spin handshake.
// Optional build macro BET_RECORDER_UNDO_EN adds an undo key (opcode 6'b111101) that removes the last bet.
module bet_recorder #(
    parameter int MAX_BETS = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    key_valid,
    input  logic [5:0]              bet_opcode,
    input  logic [2:0]              chip_color,
    input  logic                    spin_done,
    output logic [8*MAX_BETS-1:0]   bets,
    output logic [3:0]              bet_count,
    output logic                    spin_req,
    output logic                    full,
    output logic                    reject
);

    localparam logic [5:0] OP_NONE = 6'b111111;
    localparam logic [5:0] OP_SPIN = 6'b111110;
`ifdef BET_RECORDER_UNDO_EN
    localparam logic [5:0] OP_UNDO = 6'b111101;
`endif
    localparam logic [3:0] MAX_CNT = 4'(MAX_BETS);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        SKIP  = 2'd1,
        SPIN  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t state_r;

    // Keypress FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= ARMED;
            bets      <= '0;
            bet_count <= 4'd0;
            spin_req  <= 1'b0;
            full      <= 1'b0;
            reject    <= 1'b0;
        end else begin
            reject <= 1'b0;
            case (state_r)
                ARMED: begin
                    if (!key_valid || bet_opcode == OP_NONE) begin
                        state_r <= ARMED;
                    end else if (bet_opcode == OP_SPIN) begin
                        state_r  <= SPIN;
                        spin_req <= 1'b1;
`ifdef BET_RECORDER_UNDO_EN
                    end else if (bet_opcode == OP_UNDO) begin
                        state_r <= SKIP;
                        if (bet_count != 4'd0) begin
                            for (int k = 0; k < MAX_BETS; k++) begin
                                if (4'(k) == bet_count - 4'd1) begin
                                    bets[8*k +: 8] <= 8'h00;
                                end
                            end
                            bet_count <= bet_count - 4'd1;
                            full      <= 1'b0;
                        end else begin
                            reject <= 1'b1;
                        end
`endif
                    end else begin
                        // Make strobe of a bet key; its break strobe is swallowed in SKIP.
                        state_r <= SKIP;
                        if (chip_color != 3'b000 && !full) begin
                            for (int k = 0; k < MAX_BETS; k++) begin
                                if (4'(k) == bet_count) begin
                                    bets[8*k +: 8] <= {chip_color[1:0], bet_opcode};
                                end
                            end
                            bet_count <= bet_count + 4'd1;
                            full      <= (bet_count + 4'd1 == MAX_CNT);
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                SKIP: begin
                    if (key_valid && bet_opcode != OP_NONE) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= SKIP;
                    end
                end
                SPIN: begin
                    if (spin_done) begin
                        state_r   <= CLEAR;
                        spin_req  <= 1'b0;
                        bets      <= '0;
                        bet_count <= 4'd0;
                        full      <= 1'b0;
                    end else begin
                        state_r <= SPIN;
                    end
                end
                CLEAR: begin
                    state_r <= ARMED;
                end
                default: begin
                    state_r <= ARMED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bet_recorder.sv
// Self-checking bench for bet_recorder: directed scenarios plus randomized strobes against a queue-based model.
module tb_bet_recorder;

    localparam int MAX_BETS = 12;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  key_valid;
    logic [5:0]            bet_opcode;
    logic [2:0]            chip_color;
    logic                  spin_done;
    logic [8*MAX_BETS-1:0] bets;
    logic [3:0]            bet_count;
    logic                  spin_req;
    logic                  full;
    logic                  reject;

    bet_recorder #(.MAX_BETS(MAX_BETS)) dut (
        .clock      (clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .bet_opcode (bet_opcode),
        .chip_color (chip_color),
        .spin_done  (spin_done),
        .bets       (bets),
        .bet_count  (bet_count),
        .spin_req   (spin_req),
        .full       (full),
        .reject     (reject)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Behavioural model: list of placed bets plus what the recorder is waiting for.
    logic [7:0] slot_q[$];
    bit awaiting_break = 1'b0;
    bit spinning       = 1'b0;
    bit clearing       = 1'b0;
    bit exp_reject     = 1'b0;

    function automatic logic [8*MAX_BETS-1:0] model_bets();
        logic [8*MAX_BETS-1:0] e;
        e = '0;
        foreach (slot_q[i]) e[8*i +: 8] = slot_q[i];
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_apply(input logic kv, input logic [5:0] op, input logic [2:0] col,
                               input logic sd, input logic rst);
        exp_reject = 1'b0;
        if (rst) begin
            slot_q.delete();
            awaiting_break = 1'b0;
            spinning       = 1'b0;
            clearing       = 1'b0;
        end else if (clearing) begin
            clearing = 1'b0;
        end else if (spinning) begin
            if (sd) begin
                spinning = 1'b0;
                clearing = 1'b1;
                slot_q.delete();
            end
        end else if (awaiting_break) begin
            if (kv && op != 6'd63) awaiting_break = 1'b0;
        end else if (kv && op != 6'd63) begin
            if (op == 6'd62) begin
                spinning = 1'b1;
`ifdef BET_RECORDER_UNDO_EN
            end else if (op == 6'd61) begin
                awaiting_break = 1'b1;
                if (slot_q.size() > 0) void'(slot_q.pop_back());
                else exp_reject = 1'b1;
`endif
            end else begin
                awaiting_break = 1'b1;
                if (col != 3'd0 && slot_q.size() < MAX_BETS) slot_q.push_back({col[1:0], op});
                else exp_reject = 1'b1;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, compare every output at the falling edge.
    task automatic step(input logic kv, input logic [5:0] op, input logic [2:0] col,
                        input logic sd, input logic rst);
        key_valid  = kv;
        bet_opcode = op;
        chip_color = col;
        spin_done  = sd;
        reset      = rst;
        model_apply(kv, op, col, sd, rst);
        @(posedge clock);
        @(negedge clock);
        chk("bets",      128'(bets),      128'(model_bets()));
        chk("bet_count", 128'(bet_count), 128'(slot_q.size()));
        chk("spin_req",  128'(spin_req),  128'(spinning));
        chk("full",      128'(full),      128'(slot_q.size() == MAX_BETS));
        chk("reject",    128'(reject),    128'(exp_reject));
    endtask

    task automatic idle();
        step(1'b0, 6'd63, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 6'd63, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] col);
        step(1'b1, op, col, 1'b0, 1'b0);
        idle();
        step(1'b1, op, col, 1'b0, 1'b0);
        idle();
    endtask

    logic [8*MAX_BETS-1:0] saved_bets;

    initial begin
        key_valid  = 1'b0;
        bet_opcode = 6'd63;
        chip_color = 3'd0;
        spin_done  = 1'b0;
        reset      = 1'b1;

        do_reset();
        do_reset();
        chk("rst_bets",  128'(bets), 128'd0);
        chk("rst_count", 128'(bet_count), 128'd0);
        chk("rst_flags", 128'({spin_req, full, reject}), 128'd0);

        // Make then break of one bet key.
        step(1'b1, 6'h05, 3'b010, 1'b0, 1'b0);
        idle();
        step(1'b1, 6'h05, 3'b010, 1'b0, 1'b0);
        chk("first_bet_slot",  128'(bets[7:0]), 128'h85);
        chk("first_bet_count", 128'(bet_count), 128'd1);

        // No chip on the sensor.
        do_reset();
        step(1'b1, 6'h07, 3'b000, 1'b0, 1'b0);
        chk("nochip_reject", 128'(reject), 128'd1);
        chk("nochip_count",  128'(bet_count), 128'd0);
        idle();
        step(1'b1, 6'h07, 3'b000, 1'b0, 1'b0);

        // Fill every slot, then one more press.
        do_reset();
        for (int i = 0; i < MAX_BETS; i++) press(6'(i + 1), 3'b001);
        chk("fill_count", 128'(bet_count), 128'd12);
        chk("fill_full",  128'(full), 128'd1);
        chk("fill_last",  128'(bets[95:88]), 128'h4c);
        saved_bets = bets;
        step(1'b1, 6'h20, 3'b001, 1'b0, 1'b0);
        chk("over_reject", 128'(reject), 128'd1);
        chk("over_slots",  128'(bets), 128'(saved_bets));
        idle();
        step(1'b1, 6'h20, 3'b001, 1'b0, 1'b0);

        // Spin with two bets, presses ignored while spinning, then clear.
        do_reset();
        press(6'h01, 3'b011);
        press(6'h02, 3'b100);
        saved_bets = bets;
        step(1'b1, 6'd62, 3'd0, 1'b0, 1'b0);
        chk("spin_req_on", 128'(spin_req), 128'd1);
        press(6'h09, 3'b001);
        press(6'h0a, 3'b000);
        chk("spin_frozen", 128'(bets), 128'(saved_bets));
        chk("spin_frozen_cnt", 128'(bet_count), 128'd2);
        step(1'b0, 6'd63, 3'd0, 1'b1, 1'b0);
        chk("clear_bets",  128'(bets), 128'd0);
        chk("clear_count", 128'(bet_count), 128'd0);
        chk("clear_req",   128'(spin_req), 128'd0);
        idle();
        press(6'h05, 3'b010);
        chk("after_clear_bet", 128'(bets[7:0]), 128'h85);

        // Empty-table spin, then reset while spinning with three bets.
        do_reset();
        step(1'b1, 6'd62, 3'd0, 1'b0, 1'b0);
        chk("empty_spin", 128'(spin_req), 128'd1);
        step(1'b0, 6'd63, 3'd0, 1'b1, 1'b0);
        idle();
        press(6'h03, 3'b001);
        press(6'h04, 3'b001);
        press(6'h05, 3'b001);
        step(1'b1, 6'd62, 3'd0, 1'b0, 1'b0);
        step(1'b0, 6'd63, 3'd0, 1'b1, 1'b1);
        chk("midspin_rst", 128'({bets, bet_count, spin_req, full, reject}), 128'd0);

`ifdef BET_RECORDER_UNDO_EN
        do_reset();
        press(6'h01, 3'b001);
        press(6'h02, 3'b001);
        press(6'd61, 3'b001);
        chk("undo1_count", 128'(bet_count), 128'd1);
        chk("undo1_slot",  128'(bets[15:8]), 128'h00);
        press(6'd61, 3'b001);
        chk("undo2_count", 128'(bet_count), 128'd0);
        step(1'b1, 6'd61, 3'b001, 1'b0, 1'b0);
        chk("undo3_reject", 128'(reject), 128'd1);
        idle();
        step(1'b1, 6'd61, 3'b001, 1'b0, 1'b0);
`else
        do_reset();
        press(6'd61, 3'b001);
        chk("op61_is_bet", 128'(bets[7:0]), 128'h7d);
`endif

        // Randomized strobes against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [5:0] op;
            r = int'($urandom_range(0, 99));
            if (r < 20)      op = 6'd63;
            else if (r < 24) op = 6'd62;
            else if (r < 34) op = 6'd61;
            else             op = 6'($urandom_range(0, 60));
            step(($urandom_range(0, 2) == 0), op, 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 249) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bet_recorder.md
BET_RECORDER -- requirements
Module: bet_recorder

Interface
REQ-001 Parameter: MAX_BETS, default 12, number of bet slots (1..15).
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 key_valid  in  1  one-cycle strobe from the PS/2 controller; two strobes per physical keypress (make, then break).
REQ-005 bet_opcode  in  6  decoded key; 6'b111111 = no/unknown key, 6'b111110 = spin, all others = bet square.
REQ-006 chip_color  in  3  chip colour from the colour sensor; 3'b000 = no chip present.
REQ-007 spin_done  in  1  one-cycle pulse: wheel result settled and payout read.
REQ-008 bets  out  8*MAX_BETS  packed slots; slot k at [8k+7:8k]; slot = {chip_color[1:0], bet_opcode}.
REQ-009 bet_count  out  4  number of filled slots.
REQ-010 spin_req  out  1  level, high while a spin is in progress (drives the spin_check input).
REQ-011 full  out  1  high when bet_count == MAX_BETS.
REQ-012 reject  out  1  one-cycle pulse when an accepted keypress is refused.

Function
REQ-013 The FSM SHALL have states ARMED, SKIP, SPIN and CLEAR.
REQ-014 ARMED, key_valid, opcode 6'b111111 -> no effect; stay ARMED; the strobe is not counted.
REQ-015 ARMED, key_valid, opcode 6'b111110 -> SPIN next cycle; spin_req high from that cycle.
REQ-016 ARMED, key_valid, bet opcode, chip_color != 0, !full -> write slot[bet_count], increment bet_count; -> SKIP. Both take effect next cycle.
REQ-017 ARMED, key_valid, bet opcode, chip_color == 0 or full -> reject pulse next cycle, slots unchanged; -> SKIP.
REQ-018 SKIP: the next non-6'b111111 key_valid (break strobe) SHALL be consumed without effect; -> ARMED.
REQ-019 SPIN: bets and bet_count frozen; all key_valid ignored, no reject; spin_done -> CLEAR.
REQ-020 CLEAR: one cycle; all slots and bet_count zeroed; spin_req low; -> ARMED.
REQ-021 spin_done outside SPIN SHALL be ignored.
REQ-022 Spin with bet_count == 0 SHALL still enter SPIN.
REQ-023 Unfilled slots SHALL read 8'h00.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 reset SHALL override every other input in the same cycle, including a mid-spin or mid-write state.
REQ-026 After reset: state ARMED; bets all zero; bet_count 0; spin_req 0; full 0; reject 0.

Configuration
REQ-027 Macro BET_RECORDER_UNDO_EN SHALL compile in the undo feature.
REQ-028 With the macro defined: in ARMED, key_valid with opcode 6'b111101 and bet_count > 0 -> zero slot[bet_count-1], decrement bet_count, -> SKIP. With bet_count == 0 -> reject pulse, -> SKIP.
REQ-029 Without the macro: 6'b111101 SHALL be treated as an ordinary bet opcode.

Verification
REQ-030 Reset; strobes (op 6'h05, colour 3'b010) twice -> bets[7:0] = 8'h85, bet_count 1, second strobe ignored.
REQ-031 Thirteen keypresses (26 strobes) with colour 3'b001 -> bet_count 12, full 1; 13th press -> reject pulse, slots unchanged.
REQ-032 Keypress op 6'h07 with colour 3'b000 -> reject pulse, bet_count stays 0.
REQ-033 Two bets, spin press, further presses, then spin_done -> spin_req high one cycle after the spin strobe; bets frozen; after spin_done and CLEAR: bets 0, bet_count 0, spin_req 0, state ARMED.
REQ-034 Reset asserted in SPIN with bet_count 3 -> next cycle all outputs at reset values.
REQ-035 With BET_RECORDER_UNDO_EN: bets 6'h01 then 6'h02, undo press -> bet_count 1, bets[15:8] = 8'h00; second undo -> bet_count 0; third undo -> reject.
